// File: rtl/ethpipe_tx_pkg.sv
// Shared constants and types for the GMII frame transmitter.
package ethpipe_tx_pkg;

  localparam int unsigned LEN_W  = 12;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_FCS  = 3'd4,
    ST_IFG  = 3'd5
  } state_e;

  localparam logic [7:0]        PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]        SFD_BYTE       = 8'hD5;
  localparam logic [ADDR_W-1:0] SLOT_DATA_BASE = 12'd2;
  localparam logic [LEN_W-1:0]  MAX_LEN        = 12'd1514;
  localparam logic [31:0]       CRC_POLY       = 32'h04C11DB7;
  localparam logic [31:0]       CRC_INIT       = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ethpipe_tx_crc32_d8.sv
// Combinational Ethernet CRC-32 step: consumes one byte, LSB first.
module crc32_d8
  import ethpipe_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out_c
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  always_comb begin
    crc_out_c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out_c[0] ^ data_in[i]) begin
        crc_out_c = (crc_out_c >> 1) ^ POLY_R;
      end else begin
        crc_out_c = crc_out_c >> 1;
      end
    end
  end

endmodule

// File: rtl/ethpipe_tx.sv
// GMII frame transmitter: streams a slot-buffered payload with preamble,
// zero padding, FCS and inter-frame gap.
module ethpipe_tx
  import ethpipe_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MIN_LEN    = 60
) (
  input  logic                gmii_tx_clk,
  input  logic                sys_rst,
  input  logic [31:0]         global_counter,
  input  logic                tx_start,
  input  logic [LEN_W-1:0]    tx_frame_len,
  output logic [ADDR_W-1:0]   slot_tx_eth_address,
  input  logic [15:0]         slot_tx_eth_q,
  output logic [7:0]          gmii_txd,
  output logic                gmii_tx_en,
  output logic                tx_busy,
  output logic                tx_done,
  output logic                tx_err,
  output logic [31:0]         tx_timestamp
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       crc_q, crc_d;
  logic [7:0]        txd_q, txd_d;
  logic              txen_q, txen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       ts_q, ts_d;

  logic [7:0]        data_byte_c;
  logic [7:0]        crc_byte_c;
  logic [31:0]       crc_next_c;
  logic [31:0]       fcs_c;
  logic              last_data_c;
  logic              short_c;
  logic              len_ok_c;

  assign data_byte_c = cnt_q[0] ? slot_tx_eth_q[15:8] : slot_tx_eth_q[7:0];
  assign crc_byte_c  = (state_q == ST_DATA) ? data_byte_c : 8'h00;
  assign fcs_c       = ~crc_q;
  assign last_data_c = (cnt_q == (len_q - 12'd1));
  assign short_c     = (len_q < LEN_W'(MIN_LEN));
  assign len_ok_c    = (tx_frame_len != '0) && (tx_frame_len <= MAX_LEN);

  crc32_d8 u_crc (
    .crc_in    (crc_q),
    .data_in   (crc_byte_c),
    .crc_out_c (crc_next_c)
  );

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      crc_q   <= CRC_INIT;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ts_q    <= ts_d;
    end
  end

  // Each state describes the byte registered onto GMII at the coming edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    crc_d   = crc_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ts_d    = ts_q;

    case (state_q)
      ST_IDLE: begin
        // The done cycle is still part of the previous frame's turnaround.
        if (tx_start && !done_q) begin
          if (len_ok_c) begin
            state_d = ST_PRE;
            len_d   = tx_frame_len;
            cnt_d   = 12'd1;
            addr_d  = SLOT_DATA_BASE;
            crc_d   = CRC_INIT;
            busy_d  = 1'b1;
            txen_d  = 1'b1;
            txd_d   = PREAMBLE_BYTE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_PRE: begin
        txen_d = 1'b1;
        cnt_d  = cnt_q + 12'd1;
        if (cnt_q == 12'd7) begin
          txd_d   = SFD_BYTE;
          ts_d    = global_counter;
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          txd_d = PREAMBLE_BYTE;
        end
      end

      ST_DATA: begin
        txen_d = 1'b1;
        txd_d  = data_byte_c;
        crc_d  = crc_next_c;
        cnt_d  = cnt_q + 12'd1;
        // Read latency is two edges, so step the word while its even byte leaves.
        if (!cnt_q[0] && ((cnt_q + 12'd2) < len_q)) begin
          addr_d = addr_q + 12'd1;
        end
        if (last_data_c) begin
          if (short_c) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_FCS;
            cnt_d   = '0;
          end
        end
      end

      ST_PAD: begin
        txen_d = 1'b1;
        txd_d  = 8'h00;
        crc_d  = crc_next_c;
        cnt_d  = cnt_q + 12'd1;
        if (cnt_q == CNT_W'(MIN_LEN - 1)) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end
      end

      ST_FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs_c[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d  = cnt_q + 12'd1;
        if (cnt_q == 12'd3) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end
      end

      ST_IFG: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign slot_tx_eth_address = addr_q;
  assign gmii_txd            = txd_q;
  assign gmii_tx_en          = txen_q;
  assign tx_busy             = busy_q;
  assign tx_done             = done_q;
  assign tx_err              = err_q;
  assign tx_timestamp        = ts_q;

endmodule
